alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
Sequencer for the MM:SS alarm clock. It owns the alarm setting registers, compares them against the running BCD time, and drives the ringing/snooze state machine that gates the song player. It sits between the debounced button/switch inputs and the audio player. It replaces the ad-hoc compare-and-latch logic in the top level.

Parameters:
SNOOZE_SEC, 300, number of tick_1hz pulses spent in SNOOZE before re-ringing (legal 1..3599)
RING_TIMEOUT_SEC, 60, number of tick_1hz pulses in RINGING before auto-dismiss (legal 1..3599)

Ports:
clk  in  1  system clock (100 MHz)
clear  in  1  asynchronous active-high reset
tick_1hz  in  1  one-clk-wide strobe, once per second, synchronous to clk
time_bcd  in  16  running time {tens_min, ones_min, tens_sec, ones_sec}, 4 bits each
arm  in  1  alarm enable switch (level)
digit_sel  in  4  one-hot alarm digit select; bit0=ones_sec .. bit3=tens_min
inc_pulse  in  1  debounced single-clk pulse; increments the selected alarm digit
alarm_clr  in  1  single-clk pulse; zeroes alarm_bcd
dismiss  in  1  single-clk pulse; stops ringing/snooze
snooze  in  1  single-clk pulse; snoozes while ringing
alarm_bcd  out  16  current alarm setting, same packing as time_bcd
play_sound  out  1  enable to song player
state  out  2  current FSM state, for LEDs/debug
snooze_active  out  1  high in SNOOZE

Behaviour:
- Reset (async, immediate): state=DISARMED, alarm_bcd=0000, play_sound=0, snooze_active=0, ring/snooze counters=0, match_d=1. match_d=1 prevents a false ring at 00:00.
- All outputs are registered and updated on the clk edge that performs the transition. No combinational input-to-output paths.
- Alarm digit edit is accepted only in DISARMED and ARMED:
  - inc_pulse with exactly one digit_sel bit set increments that digit.
  - ones digits wrap 9->0; tens digits wrap 5->0. No carry into the next digit.
  - digit_sel zero or multi-hot: inc ignored.
  - alarm_clr sets alarm_bcd=0000; it wins over inc_pulse in the same cycle.
- Match: match = (time_bcd == alarm_bcd). match_d is registered every cycle. A ring event is match & ~match_d, i.e. a rising edge only. Arming while already matching does not ring.
- FSM states: DISARMED=0, ARMED=1, RINGING=2, SNOOZE=3. Input priority per cycle: ~arm > dismiss > snooze > tick/timeout.
  - DISARMED: arm=1 -> ARMED.
  - ARMED: ~arm -> DISARMED. Ring event -> RINGING, ring_cnt=0. Latency is 1 clk from match rising to play_sound=1.
  - RINGING: play_sound=1.
    - ~arm -> DISARMED.
    - dismiss -> ARMED.
    - snooze -> SNOOZE, snz_cnt=SNOOZE_SEC.
    - On tick: if ring_cnt == RING_TIMEOUT_SEC-1 -> ARMED, else ring_cnt+1.
  - SNOOZE: snooze_active=1, play_sound=0.
    - ~arm -> DISARMED.
    - dismiss -> ARMED.
    - snooze ignored.
    - On tick: if snz_cnt == 1 -> RINGING with ring_cnt=0, else snz_cnt-1.
- Ring events are ignored in RINGING and SNOOZE.
- Return to ARMED leaves match_d tracking, so the alarm fires again only at the next match rising edge (1 h later for MM:SS).
- Counter width: $clog2(3600)=12 bits, unsigned. Never underflows, because snz_cnt loads ≥1.
- A tick in the same cycle as a higher-priority event is consumed by that event. The counter does not also update.

Decomposition:
- Package alarm_pkg: state enum (DISARMED/ARMED/RINGING/SNOOZE, 2-bit), ONES_MAX=9, TENS_MAX=5, CNT_W=12.
- Sub-module bcd_digit_reg (parameter MAX), 4-bit register with clr, inc and wrap at MAX. Instantiated 4x with MAX=9/5/9/5.

Test Plan:
- Reset: assert clear mid-simulation without a clk edge -> alarm_bcd=0000, play_sound=0, state=0 immediately. Release with time_bcd=0000 and arm=1 -> no ring.
- Edit:
  - digit_sel=0001, 10 inc pulses -> ones_sec steps 1..9 then 0.
  - digit_sel=0010, 6 pulses -> tens_sec returns to 0.
  - digit_sel=0011 plus inc -> unchanged.
  - alarm_clr and inc together -> 0000.
- Ring/timeout (RING_TIMEOUT_SEC=4): arm=1, alarm=0130, time_bcd steps 0129->0130 -> play_sound=1 one clk later. After 4 ticks -> state=ARMED, play_sound=0. Holding 0130 -> no re-ring.
- Snooze (SNOOZE_SEC=3): while ringing, snooze pulse -> play_sound=0, snooze_active=1. On 3rd tick -> play_sound=1, state=RINGING.
- Priority:
  - dismiss+snooze in the same cycle while RINGING -> ARMED.
  - arm=0 plus dismiss -> DISARMED.
  - tick coincident with snooze -> SNOOZE with snz_cnt=SNOOZE_SEC.
- Edit lockout: inc_pulse and alarm_clr during RINGING/SNOOZE -> alarm_bcd unchanged.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the MM:SS alarm sequencer.
package alarm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } alarm_state_e;

    localparam int unsigned ONES_MAX = 9;
    localparam int unsigned TENS_MAX = 5;
    localparam int unsigned CNT_W    = 12;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Button/time/status bundle between the alarm sequencer and the rest of the clock.
interface alarm_controller_if;

    logic        tick_1hz;
    logic [15:0] time_bcd;
    logic        arm;
    logic [3:0]  digit_sel;
    logic        inc_pulse;
    logic        alarm_clr;
    logic        dismiss;
    logic        snooze;
    logic [15:0] alarm_bcd;
    logic        play_sound;
    logic [1:0]  state;
    logic        snooze_active;

    modport master (
        output tick_1hz, time_bcd, arm, digit_sel, inc_pulse, alarm_clr, dismiss, snooze,
        input  alarm_bcd, play_sound, state, snooze_active
    );

    modport slave (
        input  tick_1hz, time_bcd, arm, digit_sel, inc_pulse, alarm_clr, dismiss, snooze,
        output alarm_bcd, play_sound, state, snooze_active
    );

endinterface

// File: rtl/bcd_digit_reg.sv
// One BCD alarm digit: synchronous clear, increment with wrap at MAX, no carry out.
module bcd_digit_reg #(
    parameter int unsigned MAX = 9
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] digit_o
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    // Next digit value; clear beats increment
    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = 4'd0;
        end else if (inc_i) begin
            digit_d = (digit_q >= 4'(MAX)) ? 4'd0 : digit_q + 4'd1;
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit storage
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm setting registers, edge-detected time match and the ring/snooze sequencer
// that gates the song player.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_SEC       = 300,
    parameter int unsigned RING_TIMEOUT_SEC = 60
) (
    input  logic               clk,
    input  logic               clear,
    alarm_controller_if.slave  bus
);

    alarm_state_e     state_q;
    logic             play_q;
    logic             snz_act_q;
    logic             match_q;
    logic [CNT_W-1:0] ring_cnt_q;
    logic [CNT_W-1:0] snz_cnt_q;

    logic [15:0]      alarm_s;
    logic             edit_en_s;
    logic             clr_s;
    logic [3:0]       inc_s;
    logic             match_s;
    logic             ring_evt_s;

    // Edits are locked out once the alarm is sounding or snoozed
    always_comb begin
        edit_en_s = (state_q == DISARMED) || (state_q == ARMED);
        clr_s     = 1'b0;
        inc_s     = 4'b0000;
        if (edit_en_s) begin
            clr_s = bus.alarm_clr;
            if (bus.inc_pulse && is_onehot4(bus.digit_sel)) begin
                inc_s = bus.digit_sel;
            end else begin
                inc_s = 4'b0000;
            end
        end else begin
            clr_s = 1'b0;
            inc_s = 4'b0000;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit_reg #(
            .MAX((i % 2 == 0) ? ONES_MAX : TENS_MAX)
        ) u_digit (
            .clk    (clk),
            .clear  (clear),
            .clr_i  (clr_s),
            .inc_i  (inc_s[i]),
            .digit_o(alarm_s[4*i +: 4])
        );
    end

    assign match_s    = (bus.time_bcd == alarm_s);
    assign ring_evt_s = match_s & ~match_q;

    // Sequencer; match_q resets high so power-up at 00:00 does not ring
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q    <= DISARMED;
            play_q     <= 1'b0;
            snz_act_q  <= 1'b0;
            match_q    <= 1'b1;
            ring_cnt_q <= CNT_W'(0);
            snz_cnt_q  <= CNT_W'(0);
        end else begin
            match_q <= match_s;
            case (state_q)
                DISARMED: begin
                    if (bus.arm) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (!bus.arm) begin
                        state_q <= DISARMED;
                    end else if (ring_evt_s) begin
                        state_q    <= RINGING;
                        ring_cnt_q <= CNT_W'(0);
                        play_q     <= 1'b1;
                    end
                end
                RINGING: begin
                    if (!bus.arm) begin
                        state_q <= DISARMED;
                        play_q  <= 1'b0;
                    end else if (bus.dismiss) begin
                        state_q <= ARMED;
                        play_q  <= 1'b0;
                    end else if (bus.snooze) begin
                        state_q   <= SNOOZE;
                        snz_cnt_q <= CNT_W'(SNOOZE_SEC);
                        play_q    <= 1'b0;
                        snz_act_q <= 1'b1;
                    end else if (bus.tick_1hz) begin
                        if (ring_cnt_q == CNT_W'(RING_TIMEOUT_SEC - 1)) begin
                            state_q <= ARMED;
                            play_q  <= 1'b0;
                        end else begin
                            ring_cnt_q <= ring_cnt_q + CNT_W'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (!bus.arm) begin
                        state_q   <= DISARMED;
                        snz_act_q <= 1'b0;
                    end else if (bus.dismiss) begin
                        state_q   <= ARMED;
                        snz_act_q <= 1'b0;
                    end else if (bus.tick_1hz) begin
                        if (snz_cnt_q == CNT_W'(1)) begin
                            state_q    <= RINGING;
                            ring_cnt_q <= CNT_W'(0);
                            play_q     <= 1'b1;
                            snz_act_q  <= 1'b0;
                        end else begin
                            snz_cnt_q <= snz_cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= DISARMED;
                    play_q    <= 1'b0;
                    snz_act_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alarm_bcd     = alarm_s;
    assign bus.play_sound    = play_q;
    assign bus.state         = state_q;
    assign bus.snooze_active = snz_act_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: edit vector table plus ring/snooze/priority sequences.
module tb_alarm_controller;

    logic clk   = 1'b0;
    logic clear = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    alarm_controller_if bus();

    alarm_controller #(
        .SNOOZE_SEC      (3),
        .RING_TIMEOUT_SEC(4)
    ) dut (
        .clk  (clk),
        .clear(clear),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic        inc;
        logic        clr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_st(input string name, input logic [1:0] st, input logic play, input logic snz);
        chk({name, "_state"}, 16'(bus.state), 16'(st));
        chk({name, "_play"},  16'(bus.play_sound), 16'(play));
        chk({name, "_snz"},   16'(bus.snooze_active), 16'(snz));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.inc_pulse = 1'b0;
        bus.alarm_clr = 1'b0;
        bus.dismiss   = 1'b0;
        bus.snooze    = 1'b0;
        bus.tick_1hz  = 1'b0;
    endtask

    task automatic tick();
        bus.tick_1hz = 1'b1;
        step();
    endtask

    task automatic ring_again();
        bus.time_bcd = 16'h0131;
        step();
        bus.time_bcd = 16'h0130;
        step();
    endtask

    initial begin
        for (int k = 1; k <= 10; k++) vecs.push_back(vec_t'{4'b0001, 1'b1, 1'b0, 16'(k % 10)});
        for (int k = 1; k <= 6; k++)  vecs.push_back(vec_t'{4'b0010, 1'b1, 1'b0, 16'((k % 6) << 4)});
        vecs.push_back(vec_t'{4'b0100, 1'b1, 1'b0, 16'h0100});
        vecs.push_back(vec_t'{4'b1000, 1'b1, 1'b0, 16'h1100});
        vecs.push_back(vec_t'{4'b0011, 1'b1, 1'b0, 16'h1100});
        vecs.push_back(vec_t'{4'b0000, 1'b1, 1'b0, 16'h1100});
        vecs.push_back(vec_t'{4'b0001, 1'b1, 1'b1, 16'h0000});
        for (int k = 1; k <= 6; k++)  vecs.push_back(vec_t'{4'b1000, 1'b1, 1'b0, 16'((k % 6) << 12)});
        vecs.push_back(vec_t'{4'b0100, 1'b1, 1'b0, 16'h0100});
        for (int k = 1; k <= 3; k++)  vecs.push_back(vec_t'{4'b0010, 1'b1, 1'b0, 16'h0100 + 16'(k << 4)});

        bus.tick_1hz  = 1'b0;
        bus.time_bcd  = 16'h0000;
        bus.arm       = 1'b0;
        bus.digit_sel = 4'b0000;
        bus.inc_pulse = 1'b0;
        bus.alarm_clr = 1'b0;
        bus.dismiss   = 1'b0;
        bus.snooze    = 1'b0;
        repeat (2) @(posedge clk);
        #1 clear = 1'b0;
        chk("rst_alarm", bus.alarm_bcd, 16'h0000);
        chk_st("rst", 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.digit_sel = vecs[i].sel;
            bus.inc_pulse = vecs[i].inc;
            bus.alarm_clr = vecs[i].clr;
            step();
            chk($sformatf("edit%0d", i), bus.alarm_bcd, vecs[i].exp);
        end
        bus.digit_sel = 4'b0001;

        // Ring on match rising edge, then timeout after 4 ticks
        bus.time_bcd = 16'h0129;
        bus.arm      = 1'b1;
        step();
        chk_st("armed", 2'd1, 1'b0, 1'b0);
        bus.time_bcd = 16'h0130;
        #0 chk("pre_ring_play", 16'(bus.play_sound), 16'd0);
        step();
        chk_st("ring", 2'd2, 1'b1, 1'b0);
        repeat (3) tick();
        chk_st("ring_t3", 2'd2, 1'b1, 1'b0);
        tick();
        chk_st("timeout", 2'd1, 1'b0, 1'b0);
        repeat (3) step();
        repeat (2) tick();
        chk_st("no_rering", 2'd1, 1'b0, 1'b0);

        // Snooze for 3 ticks then re-ring
        ring_again();
        chk_st("ring2", 2'd2, 1'b1, 1'b0);
        bus.snooze = 1'b1;
        step();
        chk_st("snooze", 2'd3, 1'b0, 1'b1);
        repeat (2) tick();
        chk_st("snooze_t2", 2'd3, 1'b0, 1'b1);
        tick();
        chk_st("snooze_t3", 2'd2, 1'b1, 1'b0);

        // Edit lockout while ringing
        bus.inc_pulse = 1'b1;
        step();
        chk("lock_ring_inc", bus.alarm_bcd, 16'h0130);
        bus.alarm_clr = 1'b1;
        step();
        chk("lock_ring_clr", bus.alarm_bcd, 16'h0130);
        chk_st("lock_ring", 2'd2, 1'b1, 1'b0);

        // Tick coincident with snooze is consumed: full 3 ticks still needed
        bus.snooze   = 1'b1;
        bus.tick_1hz = 1'b1;
        step();
        chk_st("snz_tick", 2'd3, 1'b0, 1'b1);
        repeat (2) tick();
        chk_st("snz_tick_t2", 2'd3, 1'b0, 1'b1);
        bus.inc_pulse = 1'b1;
        step();
        chk("lock_snz_inc", bus.alarm_bcd, 16'h0130);
        bus.alarm_clr = 1'b1;
        step();
        chk("lock_snz_clr", bus.alarm_bcd, 16'h0130);
        bus.snooze = 1'b1;
        step();
        chk_st("snz_ignored", 2'd3, 1'b0, 1'b1);
        tick();
        chk_st("snz_tick_t3", 2'd2, 1'b1, 1'b0);

        // Priority: dismiss over snooze, ~arm over dismiss
        bus.dismiss = 1'b1;
        bus.snooze  = 1'b1;
        step();
        chk_st("dismiss_snz", 2'd1, 1'b0, 1'b0);
        ring_again();
        chk_st("ring3", 2'd2, 1'b1, 1'b0);
        bus.arm     = 1'b0;
        bus.dismiss = 1'b1;
        step();
        chk_st("disarm_dismiss", 2'd0, 1'b0, 1'b0);

        // Asynchronous reset while ringing, then release at 00:00 armed
        bus.arm = 1'b1;
        step();
        ring_again();
        chk_st("ring4", 2'd2, 1'b1, 1'b0);
        #2 clear = 1'b1;
        #1;
        chk("async_alarm", bus.alarm_bcd, 16'h0000);
        chk_st("async", 2'd0, 1'b0, 1'b0);
        bus.time_bcd = 16'h0000;
        step();
        clear = 1'b0;
        repeat (3) step();
        chk_st("no_false_ring", 2'd1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
